mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares one single-outstanding memory read port between two requesters: instruction fetch (IF, index 0) and load/store unit (LS, index 1).
- The memory side is a reqValid/addr → respValid/rdata read unit that accepts one request while idle and returns one response pulse.
- Arbitrates round-robin, issues one request at a time and routes the response back to its owner.
- Supports IF flush (drop an in-flight fetch response) and a response watchdog.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 64, max cycles in WAIT before the watchdog fires; must be ≥ 8.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept.
- req_addr0  in  XLEN  IF address.
- req_addr1  in  XLEN  LS address.
- if_flush  in  1  discard current/pending IF transaction.
- resp_valid  out  2  one-cycle response pulse per requester.
- resp_err  out  1  qualifies resp_valid; 1 = watchdog timeout, data = 0.
- resp_data  out  XLEN  response data, shared by both requesters.
- mem_req_valid  out  1  one-cycle pulse to the memory read unit.
- mem_addr  out  XLEN  address, held stable from ISSUE until the response.
- mem_resp_valid  in  1  memory response pulse.
- mem_rdata  in  XLEN  memory data.
- err_spurious  out  1  sticky: mem_resp_valid seen outside WAIT.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, last_grant=LS (so IF wins the first tie). All outputs 0: req_ready, resp_valid, resp_err, resp_data, mem_req_valid, mem_addr, err_spurious. Internal owner, drop flag and timer are also cleared.
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - req_ready is combinational and one-hot to the grant; it is never set for both requesters.
  - Grant rule: only one valid → that requester. Both valid → the requester ≠ last_grant.
  - IF is not grantable while if_flush=1.
  - On req_valid & req_ready: latch owner and address, set last_grant=owner, go to ISSUE.
- ISSUE: mem_req_valid=1 for exactly this cycle; mem_addr=latched address. Timer cleared. Go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On mem_resp_valid: register mem_rdata, go to RESP.
  - If the timer reaches TIMEOUT-1 without a response: go to RESP with resp_err=1 and data=0. A later stray mem_resp_valid sets err_spurious.
- RESP:
  - resp_valid[owner]=1 for one cycle with resp_data and resp_err, unless owner=IF and the drop flag is set. In that case nothing is asserted.
  - Drop flag cleared. Go to IDLE.
- Latency:
  - mem_resp_valid in cycle R → resp_valid in cycle R+1.
  - Next acceptance no earlier than R+2.
  - Accept-to-issue is 1 cycle.
- Flush: if_flush=1 while owner=IF in ISSUE, WAIT or RESP sets the drop flag for the current transaction. The memory transaction always completes and is never cancelled. Flush has no effect on an LS transaction.
- mem_resp_valid in IDLE, ISSUE or RESP is ignored and sets err_spurious. err_spurious clears only on reset.
- req_addr is sampled only at acceptance; later changes are ignored.
- resp_data holds its last value between pulses.
- Reset mid-transaction: immediate return to IDLE. The memory unit is reset by the same reset_n, so no stale response is expected.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - requester index constants REQ_IF=0, REQ_LS=1;
  - default XLEN and TIMEOUT.
- One natural sub-module: rr_grant2, a combinational 2-way round-robin picker taking valid[1:0], last_grant and an IF mask, and producing a one-hot grant.

Test Plan:
- Single IF read, addr 0x80000000, memory returns 0xDEADBEEF 4 cycles after mem_req_valid → exactly one mem_req_valid pulse with mem_addr=0x80000000; resp_valid[0]=1 with 0xDEADBEEF one cycle after mem_resp_valid; resp_valid[1] never asserts.
- Both requesters valid continuously (IF 0x100, LS 0x200) for 4 transactions → grants IF, LS, IF, LS; each response is routed to the correct requester; req_ready is never 2'b11.
- IF accepted at 0x104, if_flush pulsed during WAIT → memory transaction completes; no resp_valid[0]. A following LS request to 0x300 is served normally.
- Memory never responds → resp_valid with resp_err=1 and resp_data=0 exactly TIMEOUT cycles after ISSUE; a late mem_resp_valid sets err_spurious.
- Spurious mem_resp_valid in IDLE → err_spurious=1 and stays 1; no resp_valid is produced.
- reset_n asserted during WAIT → all outputs 0 asynchronously; after release, IF wins the first tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory read arbiter.
//   state_e      : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   REQ_IF/REQ_LS: requester indices (instruction fetch / load-store)
//   DEF_XLEN     : default address/data width
//   DEF_TIMEOUT  : default response watchdog limit (cycles in WAIT)
//   req_onehot() : requester index to one-hot request vector
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_TIMEOUT = 64;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin picker.
//   valid[1:0]  : per-requester request valid (bit 0 = IF, bit 1 = LS)
//   last_grant  : index of the requester granted most recently
//   if_mask     : when high, the IF requester is not eligible
//   grant[1:0]  : one-hot grant (or 2'b00 when nothing is eligible)
module rr_grant2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       if_mask,
  output logic [1:0] grant
);

  logic [1:0] elig;

  always_comb begin
    elig  = {valid[REQ_LS], valid[REQ_IF] & ~if_mask};
    grant = 2'b00;
    if (elig == 2'b11) begin
      // Tie: the requester that did not win last time goes first.
      grant = req_onehot(~last_grant);
    end else begin
      grant = elig;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one single-outstanding memory read port between instruction fetch
// (IF, index 0) and the load/store unit (LS, index 1).
//   clock, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]: per-requester handshake (ready is one-hot)
//   req_addr0/req_addr1     : IF / LS read address, sampled at acceptance
//   if_flush                : drop the current IF transaction's response
//   resp_valid[1:0]         : one-cycle response pulse to the owner
//   resp_err                : response is a watchdog timeout (data = 0)
//   resp_data               : response data, held between pulses
//   mem_req_valid/mem_addr  : one-cycle request pulse, address held to response
//   mem_resp_valid/mem_rdata: memory response pulse and data
//   err_spurious            : sticky, memory responded outside WAIT
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req_addr0,
  input  logic [XLEN-1:0] req_addr1,
  input  logic            if_flush,
  output logic [1:0]      resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_data,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err_spurious
);

  localparam int unsigned   TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic            drop_q, drop_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic            err_spurious_q, err_spurious_d;
  logic            ready_en_q, ready_en_d;

  logic [1:0]      grant;
  logic [TW-1:0]   timer_inc;
  logic            deliver;

  rr_grant2 u_grant (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .if_mask    (if_flush),
    .grant      (grant)
  );

  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    drop_d         = drop_q;
    timer_d        = timer_q;
    addr_d         = addr_q;
    data_d         = data_q;
    err_d          = err_q;
    // req_ready is combinational from req_valid; this flop holds it low
    // while reset is asserted without using reset_n as a data signal.
    ready_en_d     = 1'b1;
    err_spurious_d = err_spurious_q | (mem_resp_valid & (state_q != WAIT));
    req_ready      = 2'b00;
    mem_req_valid  = 1'b0;
    resp_valid     = 2'b00;
    resp_err       = 1'b0;
    deliver        = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = ready_en_q ? grant : 2'b00;
        if ((req_valid & req_ready) != 2'b00) begin
          owner_d      = req_ready[REQ_LS] ? REQ_LS : REQ_IF;
          addr_d       = req_ready[REQ_LS] ? req_addr1 : req_addr0;
          last_grant_d = owner_d;
          drop_d       = 1'b0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        mem_req_valid = 1'b1;
        timer_d       = '0;
        if (if_flush && (owner_q == REQ_IF)) drop_d = 1'b1;
        state_d       = WAIT;
      end

      WAIT: begin
        timer_d = timer_inc;
        if (if_flush && (owner_q == REQ_IF)) drop_d = 1'b1;
        if (mem_resp_valid) begin
          data_d  = mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_inc == TMO_LAST) begin
          // Watchdog: the response pulse lands TIMEOUT cycles after ISSUE.
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        // A flush arriving in the RESP cycle itself still suppresses the pulse.
        deliver    = !((owner_q == REQ_IF) && (drop_q || if_flush));
        resp_valid = deliver ? req_onehot(owner_q) : 2'b00;
        resp_err   = deliver & err_q;
        drop_d     = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_grant_q   <= REQ_LS;
      owner_q        <= REQ_IF;
      drop_q         <= 1'b0;
      timer_q        <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      err_q          <= 1'b0;
      err_spurious_q <= 1'b0;
      ready_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      drop_q         <= drop_d;
      timer_q        <= timer_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      err_q          <= err_d;
      err_spurious_q <= err_spurious_d;
      ready_en_q     <= ready_en_d;
    end
  end

  assign resp_data    = data_q;
  assign mem_addr     = addr_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;

  localparam int XLEN = 32;
  localparam int TMO  = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req_addr0;
  logic [XLEN-1:0] req_addr1;
  logic            if_flush;
  logic [1:0]      resp_valid;
  logic            resp_err;
  logic [XLEN-1:0] resp_data;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_rdata;
  logic            err_spurious;

  always #5 clock = ~clock;

  mem_read_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr0      (req_addr0),
    .req_addr1      (req_addr1),
    .if_flush       (if_flush),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_addr       (mem_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .err_spurious   (err_spurious)
  );

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   n_resp0 = 0;
  int   n_resp1 = 0;
  int   n_memreq = 0;
  logic mrv_prev = 1'b0;
  logic mreq_prev = 1'b0;
  bit   mem_silent = 1'b0;
  int   mem_lat_fix = 0;
  bit   inject_spur = 1'b0;
  int   model_last = 1;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD3EEF;
  endfunction

  // Round-robin rule: single eligible requester wins; on a tie the one that
  // was not granted last; IF is ineligible while flushing.
  function automatic int model_pick(input logic [1:0] v, input logic flush);
    bit e0, e1;
    e0 = v[0] && !flush;
    e1 = v[1];
    if (e0 && e1) return 1 - model_last;
    if (e1) return 1;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},     64'(req_ready),     64'(0));
    check({tag, "_resp_valid"},    64'(resp_valid),    64'(0));
    check({tag, "_resp_err"},      64'(resp_err),      64'(0));
    check({tag, "_resp_data"},     64'(resp_data),     64'(0));
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'(0));
    check({tag, "_mem_addr"},      64'(mem_addr),      64'(0));
    check({tag, "_err_spurious"},  64'(err_spurious),  64'(0));
  endtask

  task automatic wait_accept(output int owner);
    owner = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if ((req_valid & req_ready) != 2'b00) begin
        owner = req_ready[1] ? 1 : 0;
        break;
      end
    end
    if (owner < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: no grant in 60 cycles, req_valid=%b", req_valid);
    end
    @(posedge clock);
    #1;
  endtask

  // Waits for the next acceptance, checks the grant against the model and
  // records what the memory and the requester should see.
  task automatic accept_one(input string tag, input bit expect_resp, input logic exp_err,
                            output int owner);
    int          want;
    logic [31:0] a;
    exp_t        e;
    want = model_pick(req_valid, if_flush);
    a    = (want == 1) ? req_addr1 : req_addr0;
    wait_accept(owner);
    check({tag, "_grant"}, 64'(owner), 64'(want));
    if (owner >= 0) begin
      model_last = want;
      exp_addr_q.push_back(a);
      if (expect_resp) begin
        e.owner = want;
        e.data  = exp_err ? 32'h0 : mem_fn(a);
        e.err   = exp_err;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (req_ready != 2'b00) check("req_ready_not_both", 64'(req_ready == 2'b11), 64'(0));
      if (mem_req_valid) begin
        check("mem_req_single_pulse", 64'(mreq_prev), 64'(0));
        issue_cyc = cyc;
      end
      if (resp_valid != 2'b00) begin
        if (resp_valid[0]) n_resp0++;
        if (resp_valid[1]) n_resp1++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: resp_valid=%b with nothing expected", resp_valid);
        end else begin
          e = exp_q.pop_front();
          check("resp_owner", 64'(resp_valid), (e.owner == 1) ? 64'(2'b10) : 64'(2'b01));
          check("resp_data",  64'(resp_data),  64'(e.data));
          check("resp_err",   64'(resp_err),   64'(e.err));
          if (e.err) check("timeout_latency", 64'(cyc - issue_cyc), 64'(TMO));
          else       check("resp_latency",    64'(mrv_prev),        64'(1));
        end
      end
      mrv_prev  = mem_resp_valid;
      mreq_prev = mem_req_valid;
    end
  end

  // Memory read unit model
  initial begin
    logic [31:0] a;
    int          lat;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(negedge clock);
      if (inject_spur) begin
        inject_spur = 1'b0;
        @(posedge clock);
        #1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        @(posedge clock);
        #1;
        mem_resp_valid = 1'b0;
      end else if (mem_req_valid) begin
        n_memreq++;
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mem_req_unexpected: addr 0x%0h", mem_addr);
        end else begin
          check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
        end
        a = mem_addr;
        if (!mem_silent) begin
          lat = (mem_lat_fix > 0) ? mem_lat_fix : int'($urandom_range(1, 6));
          repeat (lat) @(posedge clock);
          #1;
          if (reset_n) begin
            check("mem_addr_hold", 64'(mem_addr), 64'(a));
            mem_resp_valid = 1'b1;
            mem_rdata      = mem_fn(a);
            @(posedge clock);
            #1;
            mem_resp_valid = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int         own;
    int         base_req;
    int         base_r0;
    int         base_r1;
    logic [1:0] pend;

    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_addr0 = '0;
    req_addr1 = '0;
    if_flush  = 1'b0;

    #12;
    check_all_zero("rst");
    @(posedge clock);
    #1;
    reset_n    = 1'b1;
    model_last = 1;

    // Both requesters valid continuously: IF, LS, IF, LS
    req_addr0   = 32'h0000_0100;
    req_addr1   = 32'h0000_0200;
    req_valid   = 2'b11;
    mem_lat_fix = 2;
    for (int k = 0; k < 4; k++) begin
      accept_one("rr", 1'b1, 1'b0, own);
      check("rr_order", 64'(own), 64'(k % 2));
    end
    req_valid = 2'b00;
    drain();

    // Single IF read, memory answers 4 cycles after the request
    base_req    = n_memreq;
    base_r1     = n_resp1;
    mem_lat_fix = 4;
    req_addr0   = 32'h8000_0000;
    req_valid   = 2'b01;
    accept_one("if1", 1'b1, 1'b0, own);
    req_valid   = 2'b00;
    req_addr0   = 32'hFFFF_0000;
    drain();
    check("if1_data_held",   64'(resp_data),           64'(32'hDEAD_BEEF));
    check("if1_mem_pulses",  64'(n_memreq - base_req), 64'(1));
    check("if1_no_ls_resp",  64'(n_resp1 - base_r1),   64'(0));

    // IF flushed during WAIT, then an LS read
    base_req  = n_memreq;
    base_r0   = n_resp0;
    req_addr0 = 32'h0000_0104;
    req_valid = 2'b01;
    accept_one("fl_if", 1'b0, 1'b0, own);
    req_valid = 2'b00;
    @(posedge clock);
    #1;
    if_flush  = 1'b1;
    @(posedge clock);
    #1;
    if_flush  = 1'b0;
    req_addr1 = 32'h0000_0300;
    req_valid = 2'b10;
    accept_one("fl_ls", 1'b1, 1'b0, own);
    req_valid = 2'b00;
    drain();
    check("fl_no_if_resp",   64'(n_resp0 - base_r0),   64'(0));
    check("fl_mem_pulses",   64'(n_memreq - base_req), 64'(2));

    // Randomized traffic with random memory latency
    mem_lat_fix = 0;
    pend        = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (!pend[0] && ($urandom_range(0, 1) == 1)) begin pend[0] = 1'b1; req_addr0 = $urandom; end
      if (!pend[1] && ($urandom_range(0, 1) == 1)) begin pend[1] = 1'b1; req_addr1 = $urandom; end
      if (pend == 2'b00) begin
        if ($urandom_range(0, 1) == 1) begin pend[1] = 1'b1; req_addr1 = $urandom; end
        else                           begin pend[0] = 1'b1; req_addr0 = $urandom; end
      end
      req_valid = pend;
      accept_one("rnd", 1'b1, 1'b0, own);
      if (own == 0) begin pend[0] = 1'b0; req_addr0 = $urandom; end
      if (own == 1) begin pend[1] = 1'b0; req_addr1 = $urandom; end
      req_valid = pend;
    end
    req_valid = 2'b00;
    drain();

    // Watchdog timeout, then a late response
    check("tmo_spur_initial", 64'(err_spurious), 64'(0));
    mem_silent = 1'b1;
    req_addr1  = 32'h0000_0400;
    req_valid  = 2'b10;
    accept_one("tmo", 1'b1, 1'b1, own);
    req_valid  = 2'b00;
    drain();
    check("tmo_spur_before", 64'(err_spurious), 64'(0));
    mem_silent  = 1'b0;
    inject_spur = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("tmo_late_spur", 64'(err_spurious), 64'(1));

    // Reset asserted mid-WAIT
    mem_lat_fix = 6;
    req_addr0   = 32'h0000_0500;
    req_valid   = 2'b01;
    accept_one("rstw", 1'b1, 1'b0, own);
    @(posedge clock);
    #3;
    req_valid = 2'b11;
    reset_n   = 1'b0;
    #1;
    check_all_zero("rstw");
    exp_q.delete();
    repeat (8) @(posedge clock);
    #1;
    reset_n    = 1'b1;
    model_last = 1;
    accept_one("rst_tie", 1'b1, 1'b0, own);
    check("rst_if_first", 64'(own), 64'(0));
    req_valid = 2'b00;
    drain();
    check("rst_spur_cleared", 64'(err_spurious), 64'(0));

    // Spurious response while idle
    base_r0     = n_resp0;
    base_r1     = n_resp1;
    inject_spur = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("idle_spur_set", 64'(err_spurious), 64'(1));
    repeat (5) @(posedge clock);
    #1;
    check("idle_spur_sticky", 64'(err_spurious), 64'(1));
    check("idle_spur_no_resp", 64'((n_resp0 - base_r0) + (n_resp1 - base_r1)), 64'(0));
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
